// File: rtl/riscv_pkg.sv
// riscv_pkg: instruction formats and base opcodes shared by the RV32I
// instruction encoder and its packing logic.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } inst_fmt_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

endpackage

// File: rtl/inst_pack.sv
// inst_pack: combinational packer turning decoded fields plus a byte-offset
// immediate into an RV32I word, placing each immediate bit where the core's
// immediate generator extracts it. Flags bundles that cannot be encoded.
// Define INST_ENC_RANGE_CHECK_EN to reject immediates that do not fit their
// field; otherwise immediates are silently truncated and only fmt 6-7 fail.
module inst_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

`ifdef INST_ENC_RANGE_CHECK_EN
  // An immediate fits a signed field when all bits above the field's sign
  // bit match it, i.e. the upper slice is all ones or all zeros.
  logic fits_12;
  logic fits_13;
  logic fits_21;

  assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);
`endif

  // Field placement per format, followed by the legality decision.
  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: illegal = 1'b1;
    endcase
`ifdef INST_ENC_RANGE_CHECK_EN
    case (fmt)
      FMT_I, FMT_S: if (!fits_12) illegal = 1'b1;
      FMT_B:        if (!fits_13 || imm[0]) illegal = 1'b1;
      FMT_J:        if (!fits_21 || imm[0]) illegal = 1'b1;
      FMT_U:        if (imm[11:0] != 12'h0) illegal = 1'b1;
      default:      ;
    endcase
`endif
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: accepts decoded instruction bundles over valid/ready, packs
// them into RV32I words and writes them to consecutive IMEM addresses via a
// one-entry output buffer. Rejected bundles are consumed and only counted.
// Optional build macro: INST_ENC_RANGE_CHECK_EN (immediate range checking).
module inst_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   wr_cnt,
  output logic              wrapped,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [31:0] packed_word;
  logic        pack_illegal;
  logic        accept;
  logic        write_done;

  // The buffer can take a new bundle when it is empty or draining this cycle.
  assign in_ready   = !clear && (!mem_we || mem_ready);
  assign accept     = in_valid && in_ready;
  assign write_done = mem_we && mem_ready;

  inst_pack u_pack (
    .fmt     (fmt),
    .opcode  (opcode),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .funct3  (funct3),
    .funct7  (funct7),
    .imm     (imm),
    .word    (packed_word),
    .illegal (pack_illegal)
  );

  // Write buffer, address counter and status: completion and a new accept can
  // happen together so the buffer reloads without a bubble; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      wr_cnt    <= '0;
      wrapped   <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= 8'h0;
    end else if (clear) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      wr_cnt    <= '0;
      wrapped   <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= 8'h0;
    end else begin
      if (write_done) begin
        mem_we   <= 1'b0;
        mem_addr <= mem_addr + ADDR_ONE;
        if (mem_addr == {ADDR_W{1'b1}}) wrapped <= 1'b1;
        if (wr_cnt != {(ADDR_W+1){1'b1}}) wr_cnt <= wr_cnt + CNT_ONE;
      end
      if (accept) begin
        if (pack_illegal) begin
          err <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end else begin
          mem_we    <= 1'b1;
          mem_wdata <= packed_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed bench for inst_encoder with a 4-word IMEM so the
// address wrap is reachable; expected words are hand-encoded and decoded
// back through a local model of the core's immediate generator.
module tb_inst_encoder;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        fmt = 3'd0;
  logic [6:0]        opcode = 7'd0;
  logic [4:0]        rd = 5'd0;
  logic [4:0]        rs1 = 5'd0;
  logic [4:0]        rs2 = 5'd0;
  logic [2:0]        funct3 = 3'd0;
  logic [6:0]        funct7 = 7'd0;
  logic [31:0]       imm = 32'd0;
  logic              mem_we;
  logic              mem_ready = 1'b1;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   wr_cnt;
  logic              wrapped;
  logic              err;
  logic [7:0]        err_cnt;

  int tests = 0;
  int fails = 0;

  inst_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .wr_cnt    (wr_cnt),
    .wrapped   (wrapped),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Immediate generator model of the core: recovers imm from an encoded word.
  function automatic logic [31:0] immgen(input logic [2:0] f, input logic [31:0] w);
    case (f)
      3'd1:    immgen = {{20{w[31]}}, w[31:20]};
      3'd2:    immgen = {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3:    immgen = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4:    immgen = {w[31:12], 12'h0};
      3'd5:    immgen = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: immgen = 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one bundle for exactly one clock edge, then samples after it.
  task automatic applyStimulus(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                               input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset
    #12;
    checkOutput("rst_we", {31'd0, mem_we}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_addr", {30'd0, mem_addr}, 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_wrcnt", {29'd0, wr_cnt}, 32'd0);
    checkOutput("rst_wrapped", {31'd0, wrapped}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_errcnt", {24'd0, err_cnt}, 32'd0);
    @(posedge clk); #1;

    // I-type: addi x1, x0, -1
    applyStimulus(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    checkOutput("i_we", {31'd0, mem_we}, 32'd1);
    checkOutput("i_addr", {30'd0, mem_addr}, 32'd0);
    checkOutput("i_wdata", mem_wdata, 32'hFFF0_0093);
    checkOutput("i_immgen", immgen(3'd1, mem_wdata), 32'hFFFF_FFFF);

    // S-type: sw x2, 8(x1)
    applyStimulus(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
    checkOutput("s_addr", {30'd0, mem_addr}, 32'd1);
    checkOutput("s_wdata", mem_wdata, 32'h0020_A423);
    checkOutput("s_wrcnt", {29'd0, wr_cnt}, 32'd1);
    checkOutput("s_immgen", immgen(3'd2, mem_wdata), 32'd8);

    // B-type: beq x0, x0, -4
    applyStimulus(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    checkOutput("b_addr", {30'd0, mem_addr}, 32'd2);
    checkOutput("b_wdata", mem_wdata, 32'hFE00_0EE3);
    checkOutput("b_wrcnt", {29'd0, wr_cnt}, 32'd2);
    checkOutput("b_immgen", immgen(3'd3, mem_wdata), 32'hFFFF_FFFC);

    // J-type: jal x1, 0x800
    applyStimulus(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
    checkOutput("j_addr", {30'd0, mem_addr}, 32'd3);
    checkOutput("j_wdata", mem_wdata, 32'h0010_00EF);
    checkOutput("j_wrcnt", {29'd0, wr_cnt}, 32'd3);
    checkOutput("j_wrapped", {31'd0, wrapped}, 32'd0);
    checkOutput("j_immgen", immgen(3'd5, mem_wdata), 32'h0000_0800);

    // Backpressure: J write stalls 3 cycles while a U bundle waits
    mem_ready = 1'b0;
    fmt = 3'd4; opcode = 7'b0110111; rd = 5'd5; imm = 32'h1234_5000;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("bp_we", {31'd0, mem_we}, 32'd1);
      checkOutput("bp_addr", {30'd0, mem_addr}, 32'd3);
      checkOutput("bp_wdata", mem_wdata, 32'h0010_00EF);
      checkOutput("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("u_addr_wrap", {30'd0, mem_addr}, 32'd0);
    checkOutput("u_wrapped", {31'd0, wrapped}, 32'd1);
    checkOutput("u_wrcnt", {29'd0, wr_cnt}, 32'd4);
    checkOutput("u_wdata", mem_wdata, 32'h1234_52B7);
    checkOutput("u_immgen", immgen(3'd4, mem_wdata), 32'h1234_5000);

    // Illegal fmt 7: consumed, no write, U write completes to address 0
    applyStimulus(3'd7, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    checkOutput("bad_we", {31'd0, mem_we}, 32'd0);
    checkOutput("bad_err", {31'd0, err}, 32'd1);
    checkOutput("bad_errcnt", {24'd0, err_cnt}, 32'd1);
    checkOutput("bad_addr", {30'd0, mem_addr}, 32'd1);
    checkOutput("bad_wrcnt", {29'd0, wr_cnt}, 32'd5);

    // R-type: sub x4, x2, x3 lands at the unchanged address
    applyStimulus(3'd0, 7'b0110011, 5'd4, 5'd2, 5'd3, 3'd0, 7'b0100000, 32'hDEAD_BEEF);
    checkOutput("r_we", {31'd0, mem_we}, 32'd1);
    checkOutput("r_addr", {30'd0, mem_addr}, 32'd1);
    checkOutput("r_wdata", mem_wdata, 32'h4031_0233);

    // I-type with imm=2048: out of range when checking, truncated otherwise
    applyStimulus(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
`ifdef INST_ENC_RANGE_CHECK_EN
    checkOutput("rng_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rng_errcnt", {24'd0, err_cnt}, 32'd2);
    checkOutput("rng_addr", {30'd0, mem_addr}, 32'd2);
`else
    checkOutput("trunc_we", {31'd0, mem_we}, 32'd1);
    checkOutput("trunc_wdata", mem_wdata, 32'h8000_0093);
    checkOutput("trunc_errcnt", {24'd0, err_cnt}, 32'd1);
    checkOutput("trunc_addr", {30'd0, mem_addr}, 32'd2);
`endif
    checkOutput("rng_wrcnt", {29'd0, wr_cnt}, 32'd6);

    // addi x2, x0, 5
    applyStimulus(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    checkOutput("i2_wdata", mem_wdata, 32'h0050_0113);
`ifdef INST_ENC_RANGE_CHECK_EN
    checkOutput("i2_addr", {30'd0, mem_addr}, 32'd2);
`else
    checkOutput("i2_addr", {30'd0, mem_addr}, 32'd3);
`endif

    // Drain: wr_cnt reaches 7 (saturated in the truncating build)
    @(posedge clk); #1;
    checkOutput("drain_we", {31'd0, mem_we}, 32'd0);
    checkOutput("drain_wrcnt", {29'd0, wr_cnt}, 32'd7);
    checkOutput("drain_ready", {31'd0, in_ready}, 32'd1);

    // Clear with a write in flight drops it and zeroes everything
    applyStimulus(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    checkOutput("pre_clr_we", {31'd0, mem_we}, 32'd1);
    clear = 1'b1;
    #1;
    checkOutput("clr_ready_lo", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("clr_we", {31'd0, mem_we}, 32'd0);
    checkOutput("clr_addr", {30'd0, mem_addr}, 32'd0);
    checkOutput("clr_wdata", mem_wdata, 32'd0);
    checkOutput("clr_wrcnt", {29'd0, wr_cnt}, 32'd0);
    checkOutput("clr_wrapped", {31'd0, wrapped}, 32'd0);
    checkOutput("clr_err", {31'd0, err}, 32'd0);
    checkOutput("clr_errcnt", {24'd0, err_cnt}, 32'd0);
    clear = 1'b0;
    #1;
    checkOutput("clr_ready_hi", {31'd0, in_ready}, 32'd1);

    // Reset asserted mid-write drops the write immediately
    @(posedge clk); #1;
    applyStimulus(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    mem_ready = 1'b0;
    checkOutput("prerst_we", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_we", {31'd0, mem_we}, 32'd0);
    checkOutput("midrst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder/loader for the RISC-V core: accepts decoded instruction fields plus a 32-bit immediate over a valid/ready handshake, packs them into a 32-bit RV32I word and writes it sequentially into instruction memory. Used by the self-test/boot path to build programs in IMEM. It is the inverse of the core's immediate generator and must place every immediate bit exactly where that generator extracts it.

## Interface
- ADDR_W, 8, IMEM word-address width; capacity 2^ADDR_W words
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous clear: address counter, flags and counters to 0, buffer emptied
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept this cycle
- fmt  in  3  format: R=0, I=1, S=2, B=3, U=4, J=5; 6–7 illegal
- opcode  in  7  bits [6:0]
- rd, rs1, rs2  in  5 each  register fields
- funct3  in  3  bits [14:12]
- funct7  in  7  bits [31:25], R-type only
- imm  in  32  byte-offset immediate, sign-extended
- mem_we  out  1  write strobe, held until mem_ready
- mem_ready  in  1  IMEM accepts write
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- wr_cnt  out  ADDR_W+1  successful writes since clear, saturating
- wrapped  out  1  sticky, address counter wrapped
- err  out  1  sticky, bundle rejected
- err_cnt  out  8  rejected bundles, saturating at 255

## Operation
- Accept when in_valid && in_ready; in_ready = !mem_we || mem_ready, forced 0 while clear=1.
- Encoding by fmt; fields not used by the format are ignored:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Legality (range check enabled): I/S need imm[31:11] all equal; B needs imm[31:12] equal and imm[0]=0; J needs imm[31:20] equal and imm[0]=0; U needs imm[11:0]=0; fmt 6–7 is always illegal.
- Illegal bundle: consumed (handshake completes), no write, err set, err_cnt+1, address unchanged.
- Legal bundle: one-entry output buffer loaded, mem_we=1; on mem_we && mem_ready the address counter increments, wr_cnt increments.
- Address wrap: write at 2^ADDR_W−1 completes, counter returns to 0 and wrapped is set; writing continues.
- Write completion and a new accept in the same cycle: the buffer reloads with no bubble.

## Timing
- Reset and clear values: every output 0, except in_ready, which is 1 after reset and 0 during a clear cycle.
- Latency is 1 cycle: a bundle accepted in cycle N drives mem_we/mem_addr/mem_wdata in cycle N+1.
- Throughput is 1 word/cycle with mem_ready held high.
- Under backpressure, mem_we, mem_addr and mem_wdata stay stable until mem_ready.
- Clear has priority over a write in flight: the pending write is dropped and no counter updates.
- Reset asserted mid-write drops the write immediately.

## Configuration
- INST_ENC_RANGE_CHECK_EN defined: legality checks as above, and err/err_cnt are live.
- Undefined: no range checks and immediates are truncated into their fields. fmt 6–7 is still rejected. err_cnt counts only illegal fmt.

## Structure
- Shared package riscv_pkg: inst_fmt_e enum (R..J), opcode localparams (OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR).
- Sub-module inst_pack: purely combinational, takes fmt and fields, produces the word and an illegal flag. The top level holds the handshake, buffer, counters and flags.

## Test plan
- I: fmt=I, opcode=0010011, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF -> mem_wdata=0xFFF00093, mem_addr=0, one cycle after accept.
- S: opcode=0100011, rs1=1, rs2=2, funct3=010, imm=8 -> 0x0020A423 at addr 1. B: opcode=1100011, rs1=rs2=0, funct3=0, imm=0xFFFFFFFC -> 0xFE000EE3 at addr 2.
- J: opcode=1101111, rd=1, imm=0x800 -> 0x001000EF. Encoded words fed to the core's immediate generator return the original imm.
- Illegal I with imm=2048 (check enabled) -> no mem_we, err=1, err_cnt=1, next legal word still goes to the unchanged address.
- mem_ready held low for 3 cycles -> mem_we, mem_addr and mem_wdata stable and in_ready=0; then 1 write completes.
- ADDR_W=2, 5 legal writes -> addresses 0,1,2,3,0, wrapped=1 after the 4th, wr_cnt=5. Clear -> all outputs 0.
